// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the particle-in-cell engine.
package pic_pkg;
   localparam int BWIDTH        = 16;
   localparam int PSIZE         = 64;
   localparam int DEF_ADDRWIDTH = 12;
   localparam int DEF_ITERW     = 32;
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DEPOSIT, S_SOLVE, S_PUSH} seq_state_t;
endpackage

// File: rtl/pic_rd_arb.sv
// pic_rd_arb: forwards a UI read strobe to a grid memory, parking it in a
// one-entry pending slot while the engine owns that memory.
module pic_rd_arb #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_block,
   input  logic          i_rd,
   input  logic [AW-1:0] i_addr,
   output logic          o_rd,
   output logic [AW-1:0] o_addr
);
   logic          r_pend;
   logic [AW-1:0] r_paddr;
   logic          r_rd;
   logic [AW-1:0] r_addr;
   logic          w_fire;

   assign w_fire = !i_block && (i_rd || r_pend);
   assign o_rd   = r_rd;
   assign o_addr = r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend  <= 1'b0;
         r_paddr <= '0;
         r_rd    <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_rd   <= w_fire;
         // a fresh request beats the parked one when both are present
         if (w_fire) r_addr <= i_rd ? i_addr : r_paddr;
         r_pend <= i_block ? (r_pend || i_rd) : 1'b0;
         if (i_block && i_rd) r_paddr <= i_addr;
      end
   end
endmodule

// File: rtl/pic_seq_ctrl.sv
// pic_seq_ctrl: runs CLEAR/DEPOSIT/SOLVE/PUSH iterations with a per-phase
// watchdog and arbitrates UI charge/phi reads against the active phase.
module pic_seq_ctrl
   import pic_pkg::*;
#(
   parameter int ITERW     = DEF_ITERW,
   parameter int ADDRWIDTH = DEF_ADDRWIDTH,
   parameter int TIMEOUT   = 2**20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go_wr,
   input  logic [ITERW-1:0]     go_data,
   output logic                 dep_start,
   output logic                 slv_start,
   output logic                 push_start,
   input  logic                 dep_done,
   input  logic                 slv_done,
   input  logic                 push_done,
   output logic                 clr_wr,
   output logic [ADDRWIDTH-1:0] clr_addr,
   input  logic                 ui_chrg_rd,
   input  logic [ADDRWIDTH-1:0] ui_chrg_addr,
   input  logic                 ui_phi_rd,
   input  logic [ADDRWIDTH-1:0] ui_phi_addr,
   output logic                 chrg_rd,
   output logic [ADDRWIDTH-1:0] chrg_addr,
   output logic                 phi_rd,
   output logic [ADDRWIDTH-1:0] phi_addr,
   output logic                 busy,
   output logic                 sim_done,
   output logic [ITERW-1:0]     iter_cnt,
   output logic                 timeout_err
);
   seq_state_t           r_state, w_next;
   logic                 r_first;
   logic [ADDRWIDTH-1:0] r_clr_addr;
   logic [ITERW-1:0]     r_target, r_iter, w_iter_nx;
   logic [31:0]          r_wd;
   logic                 r_timeout, r_sim_done;
   logic                 w_phase, w_done, w_adv, w_wd_hit, w_go, w_last;

   always_comb begin
      w_phase   = r_state inside {S_DEPOSIT, S_SOLVE, S_PUSH};
      w_done    = (r_state == S_DEPOSIT && dep_done) || (r_state == S_SOLVE && slv_done) ||
                  (r_state == S_PUSH && push_done);
      // done in the entry cycle belongs to a stale handshake and is ignored
      w_adv     = w_phase && !r_first && w_done;
      w_wd_hit  = (TIMEOUT != 0) && w_phase && !w_adv && r_wd == 32'(TIMEOUT - 1);
      w_go      = r_state == S_IDLE && go_wr;
      w_iter_nx = r_iter + ITERW'(1);
      w_last    = r_state == S_PUSH && w_adv && w_iter_nx == r_target;
      w_next    = r_state;
      case (r_state)
         S_IDLE:    w_next = (w_go && go_data != '0) ? S_CLEAR : S_IDLE;
         S_CLEAR:   w_next = (r_clr_addr == '1) ? S_DEPOSIT : S_CLEAR;
         S_DEPOSIT: w_next = w_adv ? S_SOLVE : S_DEPOSIT;
         S_SOLVE:   w_next = w_adv ? S_PUSH : S_SOLVE;
         S_PUSH:    w_next = w_adv ? (w_last ? S_IDLE : S_CLEAR) : S_PUSH;
         default:   w_next = S_IDLE;
      endcase
      if (w_wd_hit) w_next = S_IDLE;
      dep_start   = r_state == S_DEPOSIT && r_first;
      slv_start   = r_state == S_SOLVE && r_first;
      push_start  = r_state == S_PUSH && r_first;
      clr_wr      = r_state == S_CLEAR;
      clr_addr    = r_clr_addr;
      busy        = r_state != S_IDLE;
      sim_done    = r_sim_done;
      iter_cnt    = r_iter;
      timeout_err = r_timeout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_first    <= 1'b0;
         r_clr_addr <= '0;
         r_target   <= '0;
         r_iter     <= '0;
         r_wd       <= '0;
         r_timeout  <= 1'b0;
         r_sim_done <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_first    <= w_next != r_state;
         r_clr_addr <= (r_state == S_CLEAR) ? r_clr_addr + ADDRWIDTH'(1) : '0;
         r_wd       <= (w_next != r_state) ? '0 : r_wd + 32'd1;
         r_sim_done <= (w_go && go_data == '0) || w_last;
         if (w_go && go_data != '0) begin
            r_target  <= go_data;
            r_iter    <= '0;
            r_timeout <= 1'b0;
         end
         if (r_state == S_PUSH && w_adv) r_iter <= w_iter_nx;
         if (w_wd_hit) r_timeout <= 1'b1;
      end
   end

   pic_rd_arb #(.AW(ADDRWIDTH)) u_chrg_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_block(r_state == S_CLEAR || r_state == S_DEPOSIT),
      .i_rd   (ui_chrg_rd),
      .i_addr (ui_chrg_addr),
      .o_rd   (chrg_rd),
      .o_addr (chrg_addr)
   );

   pic_rd_arb #(.AW(ADDRWIDTH)) u_phi_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_block(r_state == S_SOLVE),
      .i_rd   (ui_phi_rd),
      .i_addr (ui_phi_addr),
      .o_rd   (phi_rd),
      .o_addr (phi_addr)
   );
endmodule
